// File: rtl/pse_pkg.sv
// rtl/pse_pkg.sv - shared types and constants for the pattern search engine
package pse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LDPAT,
        SCAN,
        WR0,
        WR1,
        WR2,
        DONE
    } pse_state_t;

    localparam int WIN       = 5;
    localparam int NWIN_BYTE = 4;

endpackage

// File: rtl/pse_window_match.sv
// rtl/pse_window_match.sv - counts 5-bit pattern hits inside a byte and across the previous-byte boundary
module pse_window_match
    import pse_pkg::*;
(
    input  logic [WIN-1:0] pat,
    input  logic [3:0]     prev,
    input  logic [7:0]     cur,
    input  logic           use_prev,
    output logic [2:0]     in_cnt,
    output logic [2:0]     x_cnt
);

    // Bits 7:0 hold the current byte, 11:8 the tail of the previous one, so
    // every window is a plain slice of this 12-bit stream.
    logic [11:0] stream;
    assign stream = {prev, cur};

    always_comb begin
        in_cnt = '0;
        x_cnt  = '0;
        for (int k = 0; k < NWIN_BYTE; k++) begin
            if (stream[k +: WIN] == pat)
                in_cnt = in_cnt + 3'd1;
            if (use_prev && (stream[k + NWIN_BYTE +: WIN] == pat))
                x_cnt = x_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/pattern_search_engine.sv
// rtl/pattern_search_engine.sv - req/done pattern counter over a 32-byte message in data memory; PSE_HITMAP_EN adds hit_map
module pattern_search_engine
    import pse_pkg::*;
#(
    parameter int NBYTES   = 32,
    parameter int PAT_ADDR = 32,
    parameter int RES_ADDR = 33,
    parameter int AW       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              done,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
`ifdef PSE_HITMAP_EN
    ,
    output logic [NBYTES-1:0] hit_map
`endif
);

    localparam int IW = $clog2(NBYTES + 1);

    pse_state_t     state, state_nx;
    logic [IW-1:0]  idx;
    logic [WIN-1:0] pat;
    logic [3:0]     prev;
    logic [7:0]     ctb, cto, cts;
    logic [2:0]     in_cnt, x_cnt;
    logic           accept;
    logic           use_prev;

    assign accept   = req && ((state == IDLE) || (state == DONE));
    assign use_prev = (idx >= IW'(2));

    pse_window_match u_match (
        .pat      (pat),
        .prev     (prev),
        .cur      (mem_rdata),
        .use_prev (use_prev),
        .in_cnt   (in_cnt),
        .x_cnt    (x_cnt)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = LDPAT;
            LDPAT:   state_nx = SCAN;
            SCAN:    if (idx == IW'(NBYTES)) state_nx = WR0;
            WR0:     state_nx = WR1;
            WR1:     state_nx = WR2;
            WR2:     state_nx = DONE;
            DONE:    if (req) state_nx = LDPAT;
            default: state_nx = IDLE;
        endcase
    end

    // Memory port is decoded from state so the address reaches the
    // synchronous memory in the same cycle the FSM needs it presented.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            LDPAT: mem_addr = AW'(PAT_ADDR);
            SCAN:  if (idx < IW'(NBYTES)) mem_addr = AW'(idx);
            WR0: begin
                mem_we    = 1'b1;
                mem_addr  = AW'(RES_ADDR);
                mem_wdata = ctb;
            end
            WR1: begin
                mem_we    = 1'b1;
                mem_addr  = AW'(RES_ADDR + 1);
                mem_wdata = cto;
            end
            WR2: begin
                mem_we    = 1'b1;
                mem_addr  = AW'(RES_ADDR + 2);
                mem_wdata = cts;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
            idx   <= '0;
            pat   <= '0;
            prev  <= '0;
            ctb   <= '0;
            cto   <= '0;
            cts   <= '0;
        end else begin
            state <= state_nx;
            done  <= (state_nx == DONE);
            if (accept) begin
                ctb  <= '0;
                cto  <= '0;
                cts  <= '0;
                pat  <= '0;
                prev <= '0;
            end
            if (state == LDPAT)
                idx <= '0;
            if (state == SCAN) begin
                idx <= idx + IW'(1);
                // Read data lags the address by one cycle: idx 0 sees the pattern byte.
                if (idx == '0) begin
                    pat <= mem_rdata[7:3];
                end else begin
                    ctb  <= ctb + {5'b0, in_cnt};
                    cto  <= cto + {7'b0, (in_cnt != 3'd0)};
                    cts  <= cts + {5'b0, in_cnt} + {5'b0, x_cnt};
                    prev <= mem_rdata[3:0];
                end
            end
        end
    end

`ifdef PSE_HITMAP_EN
    logic [IW-1:0] byte_idx;
    assign byte_idx = idx - IW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_map <= '0;
        end else if (accept) begin
            hit_map <= '0;
        end else if ((state == SCAN) && (idx != '0) && (in_cnt != 3'd0)) begin
            for (int j = 0; j < NBYTES; j++)
                if (byte_idx == IW'(j))
                    hit_map[j] <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/pattern_search_engine.md
Name: pattern_search_engine

Overview:
- Hardware responder for the program-3 request/ack protocol.
- On a `req` pulse it reads the 5-bit pattern and the 32-byte message from data memory, then computes the three pattern counts and writes them back to memory.
- It then raises `done`, exactly as the program-3 bench expects from the processor.
- Sits beside the data memory as a golden/accelerator alternative to the software program; it shares the memory's single address port.

Parameters:
- NBYTES, 32, message length in bytes; stored at addresses 0..NBYTES-1, byte 0 = most significant.
- PAT_ADDR, 32, address of pattern byte; pattern = mem[PAT_ADDR][7:3].
- RES_ADDR, 33, first result address; results go to RES_ADDR, RES_ADDR+1, RES_ADDR+2.
- AW, 8, memory address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  start request, sampled only in IDLE or DONE.
- done  out  1  ack, registered; high in DONE.
- mem_addr  out  AW  memory address (read or write).
- mem_we  out  1  write enable.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data; synchronous memory, valid 1 cycle after mem_addr is presented.

Behaviour:
- Reset (reset=0, async): state=IDLE; done=0, mem_we=0, mem_addr=0, mem_wdata=0; all counters, pattern and previous-byte registers cleared. Reset mid-operation aborts with no further writes.
- States: IDLE -> LDPAT -> SCAN -> WR0 -> WR1 -> WR2 -> DONE.
- IDLE: on req=1 go to LDPAT and clear the ctb, cto and cts counters.
- LDPAT (1 cycle): mem_addr=PAT_ADDR; next state SCAN with index i=0.
- SCAN, i=0..NBYTES (NBYTES+1 cycles):
  - mem_addr=i for i<NBYTES, otherwise don't-care (drive 0).
  - When i=0, capture pat=mem_rdata[7:3].
  - When i>=1, process byte b=mem_rdata, i.e. byte i-1:
    - w = number of matches among b[4:0], b[5:1], b[6:2], b[7:3] (0..4).
    - ctb += w.
    - cto += (w!=0).
    - cts += w.
    - If i>=2, also add to cts the crossing-window matches among {p[3:0],b[7]}, {p[2:0],b[7:6]}, {p[1:0],b[7:5]}, {p[0],b[7:4]}, where p is the previous byte. Then set p=b.
  - After i=NBYTES go to WR0.
- WR0/WR1/WR2: mem_we=1, mem_addr=RES_ADDR+0/1/2, mem_wdata=ctb/cto/cts; one cycle each.
- DONE: done=1 and mem_we=0. done stays high until req=1; that req clears done and re-enters LDPAT (restart).
- Latency: done rises on the 37th rising edge after the edge that samples req (NBYTES=32).
- req in LDPAT/SCAN/WR* is ignored.
- req held high continuously is level-sensitive: the block restarts once each time it reaches DONE.
- Widths and saturation: counters are 8 bits, no saturation needed; maxima are ctb=128, cto=32, cts=252 (4*NBYTES + 4*(NBYTES-1)). The byte index is clog2(NBYTES+1) bits.

Optional Feature:
- PSE_HITMAP_EN defined: adds output `hit_map` [NBYTES-1:0], registered.
  - Bit j is set in SCAN when byte j has w!=0.
  - Cleared in reset and on req acceptance; stable while done=1.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package pse_pkg holds:
  - state enum typedef pse_state_t {IDLE, LDPAT, SCAN, WR0, WR1, WR2, DONE};
  - localparam WIN=5 (pattern width);
  - localparam NWIN_BYTE=4.
- One sub-module, pse_window_match: combinational; inputs pat[4:0], prev[3:0], cur[7:0], use_prev; outputs in_cnt[2:0], x_cnt[2:0]. The top holds the FSM, counters and memory sequencing.

Test Plan:
- pat=00000, all bytes 0x00 -> mem[33]=128, mem[34]=32, mem[35]=252; done 37 edges after req.
- pat=10101, all bytes 0x55 -> 64, 32, 126.
- pat=11111, all bytes 0x00 -> 0, 0, 0; pat=11111, all 0xFF -> 128, 32, 252.
- pat=11000, byte0=0x03, rest 0x00 -> 0, 0, 1 (crossing-only match).
- Random pattern/bytes over 200 runs, compared against the bench's ctb/cto/cts reference loops.
- Mid-SCAN reset (i=10) -> no writes to 33..35, done=0; then req -> correct results.
- Extra req pulses during SCAN are ignored, with the cycle count unchanged.
- req in DONE -> done falls next edge and a full rerun completes.
